// File: rtl/key_word_assembler.sv
// Packs the first KEY_WORDS 32-bit words of each SOP/EOP-framed packet into one key and holds it in a one-entry output register.
// Define KEY_ASSEMBLER_STATS_EN to add the STAT_KEYS / STAT_ERRORS counter ports.
module key_word_assembler #(
    parameter  int KEY_WIDTH = 128,
    localparam int KEY_WORDS = (KEY_WIDTH - 1) / 32 + 1,
    localparam int LEN_WIDTH = $clog2(KEY_WORDS + 1)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          IN_DATA,
    input  logic                 IN_SOP,
    input  logic                 IN_EOP,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [KEY_WIDTH-1:0] OUT_KEY,
    output logic [LEN_WIDTH-1:0] OUT_LEN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY
`ifdef KEY_ASSEMBLER_STATS_EN
    ,
    output logic [31:0]          STAT_KEYS,
    output logic [15:0]          STAT_ERRORS
`endif
);

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

    localparam int ASM_WIDTH = KEY_WORDS * 32;
    localparam logic [LEN_WIDTH-1:0] LAST_IDX = LEN_WIDTH'(KEY_WORDS - 1);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [ASM_WIDTH-1:0] asm_q, asm_d;
    logic [KEY_WIDTH-1:0] out_key_q, out_key_d;
    logic [LEN_WIDTH-1:0] out_len_q, out_len_d;
    logic                 out_valid_q, out_valid_d;

    logic                 storing;
    logic                 completes;
    logic                 accept;
    logic                 error_evt;
    logic [LEN_WIDTH-1:0] idx;
    logic [ASM_WIDTH-1:0] asm_next;

    // An SOP always restarts assembly at index 0, whatever state we are in.
    always_comb begin
        storing   = IN_SOP || (state_q == COLLECT);
        idx       = IN_SOP ? '0 : count_q;
        completes = storing && (IN_EOP || (idx == LAST_IDX));
        IN_READY  = !(completes && out_valid_q && !OUT_READY);
        accept    = IN_VALID && IN_READY;
        error_evt = accept && (IN_SOP ? (state_q != IDLE) : (state_q == IDLE));

        asm_next = IN_SOP ? '0 : asm_q;
        for (int i = 0; i < KEY_WORDS; i++) begin
            if (idx == LEN_WIDTH'(i)) begin
                asm_next[i*32 +: 32] = IN_DATA;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        asm_d       = asm_q;
        out_key_d   = out_key_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q && !OUT_READY;

        if (accept && storing) begin
            asm_d = asm_next;
            if (completes) begin
                count_d     = '0;
                state_d     = IN_EOP ? IDLE : DISCARD;
                out_valid_d = 1'b1;
                out_key_d   = asm_next[KEY_WIDTH-1:0];
                out_len_d   = idx + LEN_WIDTH'(1);
            end else begin
                count_d = idx + LEN_WIDTH'(1);
                state_d = COLLECT;
            end
        end else if (accept && (state_q == DISCARD) && IN_EOP) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            count_q     <= '0;
            asm_q       <= '0;
            out_key_q   <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            asm_q       <= asm_d;
            out_key_q   <= out_key_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_KEY   = out_key_q;
    assign OUT_LEN   = out_len_q;
    assign OUT_VALID = out_valid_q;

`ifdef KEY_ASSEMBLER_STATS_EN
    logic [31:0] stat_keys_q, stat_keys_d;
    logic [15:0] stat_errors_q, stat_errors_d;

    // The error counter sticks at all-ones rather than wrapping.
    always_comb begin
        stat_keys_d   = stat_keys_q;
        stat_errors_d = stat_errors_q;
        if (out_valid_q && OUT_READY) begin
            stat_keys_d = stat_keys_q + 32'd1;
        end
        if (error_evt && (stat_errors_q != 16'hFFFF)) begin
            stat_errors_d = stat_errors_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_keys_q   <= '0;
            stat_errors_q <= '0;
        end else begin
            stat_keys_q   <= stat_keys_d;
            stat_errors_q <= stat_errors_d;
        end
    end

    assign STAT_KEYS   = stat_keys_q;
    assign STAT_ERRORS = stat_errors_q;
`else
    logic unused_error_evt;
    assign unused_error_evt = error_evt;
`endif

endmodule

// File: tb/tb_key_word_assembler.sv
// Self-checking bench for key_word_assembler: directed scenarios plus randomized packet traffic against a packet-level model.
// Stats checks are compiled in when KEY_ASSEMBLER_STATS_EN is defined.
module tb_key_word_assembler;

    localparam int KEY_WIDTH = 128;
    localparam int KW        = 4;
    localparam int LW        = 3;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [31:0]          IN_DATA;
    logic                 IN_SOP;
    logic                 IN_EOP;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [KEY_WIDTH-1:0] OUT_KEY;
    logic [LW-1:0]        OUT_LEN;
    logic                 OUT_VALID;
    logic                 OUT_READY;
`ifdef KEY_ASSEMBLER_STATS_EN
    logic [31:0]          STAT_KEYS;
    logic [15:0]          STAT_ERRORS;
`endif

    key_word_assembler #(.KEY_WIDTH(KEY_WIDTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_DATA(IN_DATA), .IN_SOP(IN_SOP), .IN_EOP(IN_EOP),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_KEY(OUT_KEY), .OUT_LEN(OUT_LEN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
`ifdef KEY_ASSEMBLER_STATS_EN
        , .STAT_KEYS(STAT_KEYS), .STAT_ERRORS(STAT_ERRORS)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [KEY_WIDTH-1:0] key;
        int                   len;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   exp_errors = 0;
    int   exp_pushed = 0;
    int   sink_mode = 0;

    logic                 held_v = 1'b0;
    logic [KEY_WIDTH-1:0] held_key;
    logic [LW-1:0]        held_len;
    exp_t                 sb_e;

    // Key built straight from the packet: word i lands at bits 32*i, only the first KW words count.
    function automatic logic [KEY_WIDTH-1:0] model_key(input logic [31:0] w[8], input int n);
        logic [KEY_WIDTH-1:0] k = '0;
        for (int i = 0; i < n && i < KW; i++) begin
            k = k | (KEY_WIDTH'(w[i]) << (32 * i));
        end
        return k;
    endfunction

    task automatic push_expect(input logic [31:0] w[8], input int n);
        exp_t e;
        e.key = model_key(w, n);
        e.len = (n < KW) ? n : KW;
        exp_q.push_back(e);
        exp_pushed++;
    endtask

    // Scoreboard: every handshake must match the next modelled key; stalled outputs must hold still.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET !== 1'b0) begin
                held_v = 1'b0;
            end else begin
                if (held_v && OUT_VALID === 1'b1) begin
                    checks++;
                    if (OUT_KEY !== held_key || OUT_LEN !== held_len) begin
                        failures++;
                        $display("[TB] FAIL stall_stable: got key=%h len=%0d, required key=%h len=%0d",
                                 OUT_KEY, OUT_LEN, held_key, held_len);
                    end
                end
                if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected_key: got key=%h len=%0d, required no key", OUT_KEY, OUT_LEN);
                    end else begin
                        sb_e = exp_q.pop_front();
                        if (OUT_KEY !== sb_e.key || OUT_LEN !== LW'(sb_e.len)) begin
                            failures++;
                            $display("[TB] FAIL scoreboard_key: got key=%h len=%0d, required key=%h len=%0d",
                                     OUT_KEY, OUT_LEN, sb_e.key, sb_e.len);
                        end
                    end
                end
                held_v   = (OUT_VALID === 1'b1) && (OUT_READY === 1'b0);
                held_key = OUT_KEY;
                held_len = OUT_LEN;
            end
        end
    end

    // Sink: mode 0 always ready, mode 1 random ready, mode 2 left to the running test.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (sink_mode == 0) OUT_READY = 1'b1;
            else if (sink_mode == 1) OUT_READY = ($urandom_range(0, 99) < 65);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop);
        int n = 0;
        IN_DATA  = d;
        IN_SOP   = sop;
        IN_EOP   = eop;
        IN_VALID = 1'b1;
        @(negedge CLK);
        while (IN_READY !== 1'b1 && n < 200) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL in_ready_timeout: got IN_READY=%b, required 1 within 200 cycles", IN_READY);
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        IN_SOP   = 1'b0;
        IN_EOP   = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] w[8], input int n, input logic with_eop);
        for (int i = 0; i < n; i++) begin
            send_word(w[i], i == 0, with_eop && (i == n - 1));
        end
    endtask

    task automatic do_reset();
        IN_VALID = 1'b0;
        IN_SOP   = 1'b0;
        IN_EOP   = 1'b0;
        IN_DATA  = '0;
        RESET    = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_q.delete();
        exp_errors = 0;
        exp_pushed = 0;
    endtask

    task automatic check_key_now(input string name, input logic [KEY_WIDTH-1:0] k, input int len);
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_KEY !== k || OUT_LEN !== LW'(len)) begin
            failures++;
            $display("[TB] FAIL %s: got valid=%b key=%h len=%0d, required valid=1 key=%h len=%0d",
                     name, OUT_VALID, OUT_KEY, OUT_LEN, k, len);
        end
    endtask

    task automatic check_valid_low(input string name);
        checks++;
        if (OUT_VALID !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s: got OUT_VALID=%b, required 0", name, OUT_VALID);
        end
    endtask

    task automatic test_reset();
        RESET    = 1'b1;
        IN_VALID = 1'b0;
        IN_SOP   = 1'b1;
        IN_EOP   = 1'b1;
        IN_DATA  = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_KEY !== '0 || OUT_LEN !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b key=%h len=%0d, required 0/0/0", OUT_VALID, OUT_KEY, OUT_LEN);
        end
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b, required 1", IN_READY);
        end
`ifdef KEY_ASSEMBLER_STATS_EN
        checks++;
        if (STAT_KEYS !== 32'd0 || STAT_ERRORS !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_stats: got keys=%0d errors=%0d, required 0/0", STAT_KEYS, STAT_ERRORS);
        end
`endif
        do_reset();
    endtask

    task automatic test_basic();
        logic [31:0] w[8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 0, 0};
        sink_mode = 0;
        push_expect(w, 4);
        send_packet(w, 4, 1'b1);
        check_key_now("basic_key", 128'h44444444_33333333_22222222_11111111, 4);
        @(posedge CLK);
        #1;
        check_valid_low("basic_one_cycle");
    endtask

    task automatic test_single();
        logic [31:0] w[8] = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0};
        push_expect(w, 1);
        send_packet(w, 1, 1'b1);
        check_key_now("single_key", 128'h00000000_00000000_00000000_DEADBEEF, 1);
    endtask

    task automatic test_long();
        logic [31:0] w[8] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 0, 0};
        logic [31:0] v[8] = '{32'hB0B0B0B0, 32'hB1B1B1B1, 0, 0, 0, 0, 0, 0};
        push_expect(w, 6);
        for (int i = 0; i < 6; i++) begin
            send_word(w[i], i == 0, i == 5);
            if (i == 3) check_key_now("long_truncated", model_key(w, 4), 4);
        end
        push_expect(v, 2);
        send_packet(v, 2, 1'b1);
        check_key_now("long_next_packet", model_key(v, 2), 2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[8] = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003, 0, 0, 0, 0};
        logic [31:0] b[8] = '{32'h20000000, 32'h20000001, 32'h20000002, 32'h20000003, 0, 0, 0, 0};
        @(posedge CLK);
        #1;
        sink_mode = 2;
        OUT_READY = 1'b0;
        push_expect(a, 4);
        push_expect(b, 4);
        send_packet(a, 4, 1'b1);
        for (int i = 0; i < 3; i++) send_word(b[i], i == 0, 1'b0);
        IN_DATA  = b[3];
        IN_SOP   = 1'b0;
        IN_EOP   = 1'b1;
        IN_VALID = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT_KEY !== model_key(a, 4)) begin
                failures++;
                $display("[TB] FAIL stall_in_ready: got ready=%b valid=%b key=%h, required ready=0 valid=1 key=%h",
                         IN_READY, OUT_VALID, OUT_KEY, model_key(a, 4));
            end
        end
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_in_ready: got %b, required 1", IN_READY);
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        IN_EOP   = 1'b0;
        check_key_now("no_bubble_load", model_key(b, 4), 4);
        sink_mode = 0;
        @(posedge CLK);
        #1;
        check_valid_low("b2b_drained");
    endtask

    task automatic test_sop_abort();
        logic [31:0] p[8] = '{32'hC0C0C0C0, 32'hC1C1C1C1, 0, 0, 0, 0, 0, 0};
        logic [31:0] q[8] = '{32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3, 0, 0, 0, 0};
        do_reset();
        sink_mode = 0;
        send_packet(p, 2, 1'b0);
        exp_errors++;
        push_expect(q, 4);
        send_packet(q, 4, 1'b1);
        check_key_now("abort_restart_key", model_key(q, 4), 4);
`ifdef KEY_ASSEMBLER_STATS_EN
        checks++;
        if (STAT_ERRORS !== 16'(exp_errors)) begin
            failures++;
            $display("[TB] FAIL abort_stat_errors: got %0d, required %0d", STAT_ERRORS, exp_errors);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] a[8] = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 0, 0, 0, 0};
        logic [31:0] b[8] = '{32'hF0F0F0F0, 32'hF1F1F1F1, 32'hF2F2F2F2, 32'hF3F3F3F3, 0, 0, 0, 0};
        @(posedge CLK);
        #1;
        sink_mode = 2;
        OUT_READY = 1'b0;
        send_packet(a, 4, 1'b1);
        send_packet(a, 2, 1'b0);
        checks++;
        if (OUT_VALID !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset_valid: got %b, required 1", OUT_VALID);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_KEY !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset: got valid=%b key=%h, required valid=0 key=0", OUT_VALID, OUT_KEY);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_q.delete();
        exp_errors = 0;
        exp_pushed = 0;
        sink_mode = 0;
        OUT_READY = 1'b1;
`ifdef KEY_ASSEMBLER_STATS_EN
        checks++;
        if (STAT_KEYS !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_stat_keys: got %0d, required 0", STAT_KEYS);
        end
`endif
        push_expect(b, 4);
        send_packet(b, 4, 1'b1);
        check_key_now("post_reset_key", model_key(b, 4), 4);
    endtask

    task automatic test_random();
        logic [31:0] w[8];
        int          n;
        int          r;
        int          wait_n;
        logic        clean;
        logic        pending_abort;
        do_reset();
        sink_mode     = 1;
        clean         = 1'b1;
        pending_abort = 1'b0;
        for (int item = 0; item < 150; item++) begin
            r = $urandom_range(0, 99);
            for (int i = 0; i < 8; i++) w[i] = $urandom;
            if (clean && r < 10 && item != 149) begin
                send_word(w[0], 1'b0, 1'($urandom_range(0, 1)));
                exp_errors++;
            end else if (!pending_abort && r < 25 && item != 149) begin
                n = $urandom_range(1, 6);
                if (n >= KW) push_expect(w, n);
                send_packet(w, n, 1'b0);
                pending_abort = 1'b1;
                clean         = 1'b0;
            end else begin
                n = $urandom_range(1, 7);
                if (pending_abort) exp_errors++;
                push_expect(w, n);
                send_packet(w, n, 1'b1);
                pending_abort = 1'b0;
                clean         = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 1000) begin
            wait_n++;
            @(posedge CLK);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL random_drain: got %0d keys outstanding, required 0", exp_q.size());
        end
        sink_mode = 0;
        repeat (3) @(posedge CLK);
        #1;
        check_valid_low("random_idle_end");
`ifdef KEY_ASSEMBLER_STATS_EN
        checks++;
        if (STAT_KEYS !== 32'(exp_pushed) || STAT_ERRORS !== 16'(exp_errors)) begin
            failures++;
            $display("[TB] FAIL random_stats: got keys=%0d errors=%0d, required keys=%0d errors=%0d",
                     STAT_KEYS, STAT_ERRORS, exp_pushed, exp_errors);
        end
`endif
    endtask

    initial begin
        OUT_READY = 1'b1;
        IN_VALID  = 1'b0;
        IN_SOP    = 1'b0;
        IN_EOP    = 1'b0;
        IN_DATA   = '0;
        RESET     = 1'b1;
        test_reset();
        test_basic();
        test_single();
        test_long();
        test_back_to_back();
        test_sop_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
